// File: rtl/mem_refill_arbiter_pkg.sv
// Shared definitions for the main-memory refill arbiter and the caches that use it.
package mem_refill_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_I_READ  = 2'd1,
    ST_D_READ  = 2'd2,
    ST_D_WRITE = 2'd3
  } state_e;

  // Which requester most recently won the memory port
  typedef enum logic {
    GNT_ICACHE = 1'b0,
    GNT_DCACHE = 1'b1
  } grant_e;

  // Line geometry and memory timing shared with the caches
  localparam int unsigned LINE_WORDS_DEF = 4;
  localparam int unsigned MEM_LAT_DEF    = 2;

  // Counter width for a count of n, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/mem_beat_timer.sv
// Paces a memory transaction: MEM_LAT cycles per word, LINE_WORDS words per line.
// Counters stay cleared while the arbiter is idle, so every transaction starts at word 0.
module mem_beat_timer
  import mem_refill_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned WORD_W     = cnt_width(LINE_WORDS),
  parameter int unsigned BEAT_W     = cnt_width(MEM_LAT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  output logic              beat_last,
  output logic [WORD_W-1:0] word_idx,
  output logic              word_last
);

  logic [BEAT_W-1:0] beat_cnt;
  logic [WORD_W-1:0] word_cnt;

  // Beat counter within a word and word index within the line
  always_ff @(posedge clk) begin
    if (!rst || !active) begin
      beat_cnt <= '0;
      word_cnt <= '0;
    end else if (beat_last) begin
      beat_cnt <= '0;
      word_cnt <= word_cnt + WORD_W'(1);
    end else begin
      beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end

  assign beat_last = (beat_cnt == BEAT_W'(MEM_LAT - 1));
  assign word_last = (word_cnt == WORD_W'(LINE_WORDS - 1));
  assign word_idx  = word_cnt;

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares the single main-memory port between ICache refills and DCache
// refills/write-throughs. Round-robin on ties, fixed per-word access latency.
module mem_refill_arbiter
  import mem_refill_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned WORD_W = cnt_width(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((LINE_WORDS * 4) - 1);

  state_e            state, state_nxt;
  grant_e            last_grant, last_grant_nxt;
  logic [ADDR_W-1:0] addr_lat, addr_nxt;
  logic [31:0]       wdata_lat, wdata_nxt;
  logic              beat_last, word_last;
  logic [WORD_W-1:0] word_idx;
  logic [ADDR_W-1:0] word_off;

  mem_beat_timer #(
    .LINE_WORDS (LINE_WORDS),
    .MEM_LAT    (MEM_LAT),
    .WORD_W     (WORD_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .active    (state != ST_IDLE),
    .beat_last (beat_last),
    .word_idx  (word_idx),
    .word_last (word_last)
  );

  // Base is line-aligned, so adding the word offset never carries into the next line
  assign word_off = ADDR_W'({word_idx, 2'b00});

  // State, round-robin pointer and latched transaction address/data
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_grant <= GNT_ICACHE;
      addr_lat   <= '0;
      wdata_lat  <= 32'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      addr_lat   <= addr_nxt;
      wdata_lat  <= wdata_nxt;
    end
  end

  // Arbitration in IDLE and end-of-transaction detection
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    addr_nxt       = addr_lat;
    wdata_nxt      = wdata_lat;
    case (state)
      ST_IDLE: begin
        if (d_req && (!i_req || (last_grant == GNT_ICACHE))) begin
          last_grant_nxt = GNT_DCACHE;
          if (d_we) begin
            state_nxt = ST_D_WRITE;
            addr_nxt  = {d_addr[ADDR_W-1:2], 2'b00};
            wdata_nxt = d_wdata;
          end else begin
            state_nxt = ST_D_READ;
            addr_nxt  = d_addr & LINE_MASK;
            wdata_nxt = 32'd0;
          end
        end else if (i_req) begin
          last_grant_nxt = GNT_ICACHE;
          state_nxt      = ST_I_READ;
          addr_nxt       = i_addr & LINE_MASK;
          wdata_nxt      = 32'd0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_I_READ, ST_D_READ: begin
        if (beat_last && word_last) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = state;
        end
      end
      ST_D_WRITE: begin
        if (beat_last) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = state;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Memory port drive and per-requester data/valid/done decode
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    i_rdata   = 32'd0;
    i_rvalid  = 1'b0;
    i_done    = 1'b0;
    d_rdata   = 32'd0;
    d_rvalid  = 1'b0;
    d_done    = 1'b0;
    case (state)
      ST_I_READ: begin
        mem_en   = 1'b1;
        mem_addr = addr_lat + word_off;
        i_rvalid = beat_last;
        i_rdata  = beat_last ? mem_rdata : 32'd0;
        i_done   = beat_last && word_last;
      end
      ST_D_READ: begin
        mem_en   = 1'b1;
        mem_addr = addr_lat + word_off;
        d_rvalid = beat_last;
        d_rdata  = beat_last ? mem_rdata : 32'd0;
        d_done   = beat_last && word_last;
      end
      ST_D_WRITE: begin
        mem_en    = 1'b1;
        mem_addr  = addr_lat;
        mem_wdata = wdata_lat;
        mem_we    = beat_last;
        d_done    = beat_last;
      end
      default: mem_en = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Scoreboard bench for mem_refill_arbiter (LINE_WORDS=4, MEM_LAT=2).
// DM model: word at byte address a reads as a unless it has been written.
module tb_mem_refill_arbiter;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    int          cyc;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        i_rvalid, i_done, d_rvalid, d_done, mem_en, mem_we;

  int   cyc = 0;
  int   n_pass = 0, n_total = 0, viol = 0;
  exp_t iq[$], dq[$], wq[$];
  exp_t mon_e;

  logic        wr_seen = 1'b0;
  logic [31:0] wr_addr = 32'd0, wr_data = 32'd0;

  mem_refill_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DM model: one tracked written word, everything else reads back its address
  assign mem_rdata = (wr_seen && (mem_addr == wr_addr)) ? wr_data : mem_addr;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wr_seen <= 1'b1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Queue one line burst granted in IDLE cycle gc; word 0 data given explicitly
  task automatic push_burst(input bit side_d, input logic [31:0] base, input int gc,
                            input logic [31:0] w0);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.addr = base + 32'(4 * k);
      e.data = (k == 0) ? w0 : e.addr;
      e.cyc  = gc + 2 + 2 * k;
      e.done = (k == 3);
      if (side_d) dq.push_back(e);
      else iq.push_back(e);
    end
  endtask

  // ICache requester: holds i_req across ntxn done pulses, then drops it
  task automatic i_txn(input logic [31:0] addr, input int ntxn);
    int seen = 0;
    i_req  = 1'b1;
    i_addr = addr;
    for (int n = 0; n < 60 && seen < ntxn; n++) begin
      @(negedge clk);
      if (i_done) seen++;
    end
    chk("i_done_count", 32'(seen), 32'(ntxn));
    i_req = 1'b0;
  endtask

  // DCache requester: single transaction
  task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int seen = 0;
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    for (int n = 0; n < 60 && seen < 1; n++) begin
      @(negedge clk);
      if (d_done) seen++;
    end
    chk("d_done_count", 32'(seen), 32'd1);
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  task automatic gap();
    repeat (3) @(negedge clk);
  endtask

  // Monitor: pop and compare whenever the DUT presents data or a write strobe
  always @(negedge clk) begin
    if (i_rvalid) begin
      if (iq.size() == 0) chk("i_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        mon_e = iq.pop_front();
        chk("i_rdata", i_rdata, mon_e.data);
        chk("i_addr", mem_addr, mon_e.addr);
        chk("i_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("i_done", {31'd0, i_done}, {31'd0, mon_e.done});
      end
    end
    if (d_rvalid) begin
      if (dq.size() == 0) chk("d_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        mon_e = dq.pop_front();
        chk("d_rdata", d_rdata, mon_e.data);
        chk("d_addr", mem_addr, mon_e.addr);
        chk("d_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("d_done", {31'd0, d_done}, {31'd0, mon_e.done});
      end
    end
    if (mem_en && mem_we) begin
      if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        mon_e = wq.pop_front();
        chk("w_addr", mem_addr, mon_e.addr);
        chk("w_data", mem_wdata, mon_e.data);
        chk("w_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("w_done", {31'd0, d_done}, 32'd1);
      end
    end
    if (!mem_en && (mem_we || mem_addr != 32'd0 || mem_wdata != 32'd0)) viol++;
    if (i_rvalid && d_rvalid) viol++;
    if (mem_we && (i_rvalid || d_rvalid)) viol++;
    if (i_done && !i_rvalid) viol++;
    if (d_done && !d_rvalid && !mem_we) viol++;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    exp_t e;
    // Reset: everything quiet
    repeat (3) @(negedge clk);
    chk("rst_flags", {26'd0, i_rvalid, i_done, d_rvalid, d_done, mem_en, mem_we}, 32'd0);
    chk("rst_data", mem_addr | mem_wdata | i_rdata | d_rdata, 32'd0);
    rst = 1'b1;
    gap();

    // First tie after reset: DCache first, ICache granted in IDLE cycle c+9
    c = cyc;
    push_burst(1'b1, 32'h200, c, 32'h200);
    push_burst(1'b0, 32'h100, c + 9, 32'h100);
    fork
      i_txn(32'h104, 1);
      d_txn(1'b0, 32'h208, 32'd0);
    join
    gap();

    // Lone ICache refill of 0x104: rvalid at c+2,4,6,8
    c = cyc;
    push_burst(1'b0, 32'h100, c, 32'h100);
    i_txn(32'h104, 1);
    gap();

    // Write-through to 0x203: strobe at c+2, address 0x200
    c = cyc;
    e.addr = 32'h200; e.data = 32'hDEADBEEF; e.cyc = c + 2; e.done = 1'b1;
    wq.push_back(e);
    d_txn(1'b1, 32'h203, 32'hDEADBEEF);
    gap();

    // Read back the written line
    c = cyc;
    push_burst(1'b1, 32'h200, c, 32'hDEADBEEF);
    d_txn(1'b0, 32'h200, 32'd0);
    gap();

    // Tie with DCache as last grant: ICache goes first
    c = cyc;
    push_burst(1'b0, 32'h0F0, c, 32'h0F0);
    push_burst(1'b1, 32'h310, c + 9, 32'h310);
    fork
      i_txn(32'h0F4, 1);
      d_txn(1'b0, 32'h310, 32'd0);
    join
    gap();

    // DCache request arriving mid ICache burst waits for the first IDLE
    c = cyc;
    push_burst(1'b0, 32'h120, c, 32'h120);
    push_burst(1'b1, 32'h130, c + 9, 32'h130);
    fork
      i_txn(32'h12C, 1);
      begin
        repeat (3) @(negedge clk);
        d_txn(1'b0, 32'h134, 32'd0);
      end
    join
    gap();

    // Request held one cycle past done: a second full burst follows
    c = cyc;
    push_burst(1'b0, 32'h140, c, 32'h140);
    push_burst(1'b0, 32'h140, c + 9, 32'h140);
    i_txn(32'h148, 2);
    gap();

    // Reset during a burst: two words, then restart from word 0, single done
    c = cyc;
    e.addr = 32'h160; e.data = 32'h160; e.cyc = c + 2; e.done = 1'b0;
    iq.push_back(e);
    e.addr = 32'h164; e.data = 32'h164; e.cyc = c + 4; e.done = 1'b0;
    iq.push_back(e);
    push_burst(1'b0, 32'h160, c + 6, 32'h160);
    fork
      i_txn(32'h168, 1);
      begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_flags", {26'd0, i_rvalid, i_done, d_rvalid, d_done, mem_en, mem_we}, 32'd0);
        chk("midrst_addr", mem_addr, 32'd0);
        rst = 1'b1;
      end
    join
    gap();

    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("invariant_violations", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
